// File: rtl/ui_pkg.sv
// ui_pkg: types and width helpers shared by the user-interface blocks
// (the LED pulse stretcher and the key debouncer).
//   stretch_state_t : FSM states of the pulse stretcher
//   cnt_w(n)        : counter width for n values, never less than 1 bit
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } stretch_state_t;

    // $clog2 returns 0 for n<=1; a zero-width counter cannot be declared.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ui_timer.sv
// ui_timer: loadable down-counter with zero detect.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, counter clears to 0
//   load     : load load_val this cycle (wins over dec)
//   load_val : value to load
//   dec      : decrement by one (caller only asserts it while nonzero)
//   zero     : counter currently equals 0
module ui_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle event strobes into LED blinks of
// ON_CNT cycles high followed by at least OFF_CNT cycles low.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, aborts any blink at once
//   pulse_in : event strobe, one event per high cycle
//   ovf_clr  : synchronous clear of overflow (a same-cycle set wins)
//   led_out  : registered LED drive, active-high
//   busy     : registered, high while blinking or in the gap after a blink
//   pending  : number of queued blinks not yet started
//   overflow : sticky, set whenever an event is dropped
// Build option: define LED_STRETCH_QUEUE_EN to queue events that arrive
// while busy (up to MAX_PENDING). Without it pending is tied to 0 and every
// event arriving while busy is dropped.
module led_pulse_stretcher
    import ui_pkg::*;
#(
    parameter int ON_CNT      = 5_000_000,
    parameter int OFF_CNT     = 5_000_000,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pulse_in,
    input  logic                               ovf_clr,
    output logic                               led_out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int MAX_CNT = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
    localparam int TMR_W   = cnt_w(MAX_CNT);
    localparam int PEND_W  = $clog2(MAX_PENDING + 1);

    stretch_state_t   state_d, state_q;
    logic             led_d, led_q;
    logic             busy_d, busy_q;
    logic             ovf_d, ovf_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // Event seen in ON/GAP that was not consumed by a GAP exit.
    logic             busy_evt;
    logic             drop;

`ifdef LED_STRETCH_QUEUE_EN
    logic [PEND_W-1:0] pend_d, pend_q;
    logic              deq;
    logic              exit_enq;
`else
    logic              exit_drop;
`endif

    ui_timer #(
        .W (TMR_W)
    ) u_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state and timer control.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        busy_evt = 1'b0;
`ifdef LED_STRETCH_QUEUE_EN
        deq      = 1'b0;
        exit_enq = 1'b0;
`else
        exit_drop = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = ON;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ON_CNT - 1);
                end
            end
            ON: begin
                busy_evt = pulse_in;
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OFF_CNT - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
`ifdef LED_STRETCH_QUEUE_EN
                    if (pend_q != '0) begin
                        // Queued blink starts; a same-edge event takes its
                        // place in the queue, so the count holds.
                        state_d  = ON;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(ON_CNT - 1);
                        deq      = 1'b1;
                        exit_enq = pulse_in;
                    end else if (pulse_in) begin
                        // Empty queue: the event starts its blink directly.
                        state_d  = ON;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(ON_CNT - 1);
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d   = IDLE;
                    exit_drop = pulse_in;
`endif
                end else begin
                    busy_evt = pulse_in;
                    tmr_dec  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef LED_STRETCH_QUEUE_EN
    // Pending counter: dequeue at GAP exit, enqueue while busy, saturate.
    always_comb begin
        pend_d = pend_q;
        drop   = 1'b0;
        if (deq) begin
            if (!exit_enq) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end else if (busy_evt) begin
            if (pend_q < PEND_W'(MAX_PENDING)) begin
                pend_d = pend_q + PEND_W'(1);
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
`else
    always_comb begin
        drop = busy_evt | exit_drop;
    end

    assign pending = '0;
`endif

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
        ovf_d  = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
